spi_master: RTL and testbench

- Synchronous SPI mode-0 master that drives the SCK/SS/MOSI lines of the SPI slave block and captures its MISO.
- Sits between the PCLK-domain register/control logic and the slave's serial pins.
- Performs one 8-bit MSB-first full-duplex frame per START request.
- All outputs, including SCK, are registers in the PCLK domain.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sck_gen.sv | 40 ++++
 rtl/spi_master.sv | 190 +++++++++++++++++++
 tb/tb_spi_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM state encoding and frame constants.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0      = 2'b00;
  localparam int         SPI_FRAME_BITS = 8;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer for the SPI master. A load restarts the count; while enabled it
// strobes phase_end on the last PCLK cycle of every SCK half period and reloads itself.
module spi_sck_gen #(
  parameter int HALF_PERIOD = 4,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic phase_end
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign phase_end = en && (cnt_q == '0);

  // Next count: restart on load, otherwise count down and wrap at the end of each half period.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one 8-bit MSB-first full-duplex frame per accepted START.
// All pin outputs, including SCK, are PCLK-domain registers.
// Optional build macro SPI_MSTR_MISO_SYNC_EN: MISO passes through a 2-flop synchronizer
// before it is sampled (requires HALF_PERIOD >= 3); frame timing is unchanged.
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int CNT_W       = 8
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       START,
  input  logic [1:0] MODE,
  input  logic [7:0] TX_DATA,
  output logic [7:0] RX_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic       SCK,
  output logic       SS,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [2:0] LAST_BIT = 3'(SPI_FRAME_BITS - 1);

  if (HALF_PERIOD < 2 || HALF_PERIOD > 255) begin : g_hp_range_chk
    $error("spi_master: HALF_PERIOD must lie in 2..255");
  end
  if ((1 << CNT_W) <= HALF_PERIOD) begin : g_cnt_w_chk
    $error("spi_master: CNT_W too narrow for HALF_PERIOD");
  end

  logic miso_s;

`ifdef SPI_MSTR_MISO_SYNC_EN
  if (HALF_PERIOD < 3) begin : g_sync_hp_chk
    $error("spi_master: MISO synchronizer needs HALF_PERIOD >= 3");
  end

  logic miso_meta_q;
  logic miso_sync_q;

  // Two-flop synchronizer on the incoming serial data.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      miso_meta_q <= MISO;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign miso_s = miso_sync_q;
`else
  assign miso_s = MISO;
`endif

  spi_state_e state_q, state_d;
  logic       sck_q, sck_d;
  logic       ss_q, ss_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [7:0] tx_sr_q, tx_sr_d;
  logic [7:0] rx_sr_q, rx_sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       cnt_load;
  logic       phase_end;

  spi_sck_gen #(
    .HALF_PERIOD (HALF_PERIOD),
    .CNT_W       (CNT_W)
  ) u_sck_gen (
    .clk       (PCLK),
    .rst       (PRESET),
    .load      (cnt_load),
    .en        (state_q != IDLE),
    .phase_end (phase_end)
  );

  // Frame sequencing: every state change happens on the last cycle of a half period.
  always_comb begin
    state_d   = state_q;
    sck_d     = sck_q;
    ss_d      = ss_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rx_data_d = rx_data_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    cnt_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          if (MODE == SPI_MODE0) begin
            cnt_load  = 1'b1;
            tx_sr_d   = TX_DATA;
            bit_cnt_d = '0;
            ss_d      = 1'b0;
            mosi_d    = TX_DATA[7];
            busy_d    = 1'b1;
            state_d   = SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          rx_sr_d = {rx_sr_q[6:0], miso_s};
          sck_d   = 1'b0;
          state_d = LOW;
          if (bit_cnt_q != LAST_BIT) begin
            // Rotating keeps every bit live; only the top bit ever reaches MOSI.
            tx_sr_d = {tx_sr_q[6:0], tx_sr_q[7]};
            mosi_d  = tx_sr_q[6];
          end
        end
      end
      LOW: begin
        if (phase_end) begin
          if (bit_cnt_q != LAST_BIT) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sck_d     = 1'b1;
            state_d   = HIGH;
          end else begin
            ss_d      = 1'b1;
            rx_data_d = rx_sr_q;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      sck_q     <= 1'b0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rx_data_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sck_q     <= sck_d;
      ss_q      <= ss_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rx_data_q <= rx_data_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign SCK     = sck_q;
  assign SS      = ss_q;
  assign MOSI    = mosi_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign RX_DATA = rx_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master (HALF_PERIOD=4): directed frames against a behavioural mode-0
// slave or a MOSI->MISO self-loop; expected RX bytes are queued at stimulus time and
// popped by a monitor whenever DONE pulses.
module tb_spi_master;

  localparam int HP = 4;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       START;
  logic [1:0] MODE;
  logic [7:0] TX_DATA;
  logic [7:0] RX_DATA;
  logic       BUSY, DONE, ERR, SCK, SS, MOSI, MISO;

  always #5 PCLK = ~PCLK;

  spi_master #(.HALF_PERIOD(HP), .CNT_W(8)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .START   (START),
    .MODE    (MODE),
    .TX_DATA (TX_DATA),
    .RX_DATA (RX_DATA),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR),
    .SCK     (SCK),
    .SS      (SS),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural mode-0 slave: loads its byte on SS fall, samples on SCK rise, shifts on SCK fall.
  logic [7:0] slv_data = 8'h00;
  logic [7:0] slv_tx = 8'h00;
  logic [7:0] slv_rx = 8'h00;
  logic [7:0] slv_out = 8'h00;
  logic       slv_miso = 1'b0;
  bit         loop = 1'b0;

  always @(negedge SS) begin
    slv_tx   = slv_data;
    slv_miso = slv_data[7];
  end
  always @(posedge SCK) if (SS === 1'b0) slv_rx = {slv_rx[6:0], MOSI};
  always @(negedge SCK) if (SS === 1'b0) begin
    slv_tx   = {slv_tx[6:0], 1'b0};
    slv_miso = slv_tx[7];
  end
  always @(posedge SS) slv_out = slv_rx;

  assign MISO = loop ? MOSI : slv_miso;

  // Scoreboard and pin-timing monitor, sampled on the falling PCLK edge.
  logic [7:0] exp_q[$];
  int  cyc = 0, done_cnt = 0, err_cnt = 0;
  int  ss_fall_cyc = 0, ss_rise_cyc = 0, rises = 0, falls = 0, last_rise = 0, last_fall = 0;
  logic prev_sck = 1'b0, prev_ss = 1'b1;
  bit  mon_en = 1'b0, abort = 1'b0, chk_gap = 1'b0;

  always @(negedge PCLK) begin
    cyc++;
    if (mon_en) begin
      if (prev_ss && !SS) begin
        if (chk_gap) chk("ss_high_gap", cyc - ss_rise_cyc, 1);
        ss_fall_cyc = cyc;
        last_fall   = cyc;
        rises       = 0;
        falls       = 0;
      end
      if (!prev_sck && SCK) begin
        rises++;
        chk("sck_low_width", cyc - last_fall, HP);
        last_rise = cyc;
      end
      if (prev_sck && !SCK) begin
        falls++;
        if (!abort) chk("sck_high_width", cyc - last_rise, HP);
        last_fall = cyc;
      end
      if (!prev_ss && SS) begin
        if (!abort) begin
          chk("ss_low_cycles", cyc - ss_fall_cyc, 17 * HP);
          chk("sck_rises", rises, 8);
          chk("sck_falls", falls, 8);
        end
        ss_rise_cyc = cyc;
      end
      if (DONE) begin
        done_cnt++;
        chk("done_latency", cyc - ss_fall_cyc + 1, 1 + 17 * HP);
        chk("busy_at_done", BUSY, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got DONE with rx %0h expected no DONE", RX_DATA);
        end else begin
          chk("rx_data", RX_DATA, exp_q.pop_front());
        end
      end
      if (ERR) err_cnt++;
    end
    prev_sck = SCK;
    prev_ss  = SS;
  end

  task automatic wait_done(input int tgt);
    int k = 0;
    while (done_cnt < tgt && k < 400) begin
      @(posedge PCLK);
      k++;
    end
    chk("done_seen", (done_cnt >= tgt), 1);
    #1;
  endtask

  task automatic do_frame(input logic [7:0] tx, input logic [7:0] exp);
    int tgt;
    tgt = done_cnt + 1;
    exp_q.push_back(exp);
    TX_DATA = tx;
    START   = 1'b1;
    @(posedge PCLK); #1;
    START   = 1'b0;
    wait_done(tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, tgt;
    PRESET = 1'b1; START = 1'b0; MODE = 2'b00; TX_DATA = 8'h00;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_ss", SS, 1);
    chk("rst_sck", SCK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_rx", RX_DATA, 8'h00);
    PRESET = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;

    // Slave loopback: A5 out, 3C back.
    loop = 1'b0; slv_data = 8'h3C;
    do_frame(8'hA5, 8'h3C);
    chk("slave_out_a5", slv_out, 8'hA5);

    // Self-loop: byte comes straight back, exactly one DONE.
    loop = 1'b1;
    d0 = done_cnt;
    do_frame(8'h81, 8'h81);
    repeat (20) @(posedge PCLK);
    #1;
    chk("single_done", done_cnt, d0 + 1);

    // Unsupported mode: ERR pulse only.
    d0 = done_cnt; e0 = err_cnt;
    MODE = 2'b01; START = 1'b1;
    @(posedge PCLK); #1;
    chk("err_pulse", ERR, 1);
    chk("err_ss", SS, 1);
    chk("err_sck", SCK, 0);
    chk("err_busy", BUSY, 0);
    START = 1'b0; MODE = 2'b00;
    @(posedge PCLK); #1;
    chk("err_one_cycle", ERR, 0);
    repeat (100) @(posedge PCLK);
    #1;
    chk("err_no_done", done_cnt, d0);
    chk("err_count", err_cnt, e0 + 1);

    // START held high: back-to-back frames, one idle cycle between.
    loop = 1'b1;
    tgt = done_cnt + 1;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    TX_DATA = 8'h55; START = 1'b1;
    @(posedge PCLK); #1;
    TX_DATA = 8'hAA;
    wait_done(tgt);
    chk_gap = 1'b1;
    START = 1'b0;
    wait_done(tgt + 1);
    chk_gap = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;

    // START and TX_DATA changes while busy are ignored.
    e0 = err_cnt;
    tgt = done_cnt + 1;
    exp_q.push_back(8'h3A);
    TX_DATA = 8'h3A; START = 1'b1;
    @(posedge PCLK); #1;
    START = 1'b0;
    repeat (10) @(posedge PCLK);
    #1;
    TX_DATA = 8'hFF; MODE = 2'b01; START = 1'b1;
    @(posedge PCLK); #1;
    START = 1'b0;
    repeat (5) @(posedge PCLK);
    #1;
    MODE = 2'b00;
    wait_done(tgt);
    chk("busy_start_no_err", err_cnt, e0);

    // Reset on cycle 30 of a frame aborts it.
    loop = 1'b0; slv_data = 8'hC3;
    TX_DATA = 8'h5A; START = 1'b1;
    @(posedge PCLK); #1;
    START = 1'b0;
    repeat (28) @(posedge PCLK);
    #1;
    abort = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk("abort_ss", SS, 1);
    chk("abort_sck", SCK, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_rx", RX_DATA, 8'h00);
    chk("abort_mosi", MOSI, 0);
    PRESET = 1'b0;
    d0 = done_cnt;
    repeat (100) @(posedge PCLK);
    #1;
    abort = 1'b0;
    chk("abort_no_done", done_cnt, d0);

    // Fresh frame after the abort.
    do_frame(8'h5A, 8'hC3);
    chk("slave_out_5a", slv_out, 8'h5A);
    repeat (5) @(posedge PCLK);
    #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
